// File: rtl/aes_pkg.sv
// Shared AES datapath types and helpers for the round pipeline.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTE_W  = 8;
    localparam int unsigned AES_NBYTES  = AES_STATE_W / AES_BYTE_W;

    typedef logic [AES_STATE_W-1:0] aes_state_t;
    typedef logic [3:0]             aes_round_t;

    function automatic aes_state_t aes_xor_key(input aes_state_t state, input aes_state_t key);
        return state ^ key;
    endfunction

    // Bit k covers state[8k+7:8k], so bit 15 belongs to byte 0 at [127:120].
    function automatic logic [AES_NBYTES-1:0] aes_byte_parity(input aes_state_t state);
        logic [AES_NBYTES-1:0] par;
        par = '0;
        for (int unsigned i = 0; i < AES_NBYTES; i++) begin
            par[i] = ^state[i*AES_BYTE_W +: AES_BYTE_W];
        end
        return par;
    endfunction

endpackage

// File: rtl/aes_skid_buf.sv
// Two-entry FIFO-ordered skid buffer with a registered in_ready (set while fewer than 2 entries are held).
module aes_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push      = in_valid & ready_q;
    assign pop       = (count_q != 2'd0) & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= in_data;
                    else                 tail_q <= in_data;
                end
                2'b01: head_q <= tail_q;
                // Push with pop: head advances, the new beat lands behind whatever remains.
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= in_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/addroundkey_stage.sv
// Registered AddRoundKey stage: XOR with round key at entry, round-sequence checking, skid-buffered output.
// Optional per-byte parity output out_par is enabled by defining ADDKEY_PARITY_EN.
module addroundkey_stage
    import aes_pkg::*;
#(
    parameter int unsigned NR      = 10,
    parameter int unsigned ROUND_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic [AES_STATE_W-1:0] in_key,
    input  logic [ROUND_W-1:0]     in_round,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic [ROUND_W-1:0]     out_round,
    output logic                   out_last,
    output logic                   round_err
`ifdef ADDKEY_PARITY_EN
    ,
    output logic [AES_NBYTES-1:0]  out_par
`endif
);

`ifdef ADDKEY_PARITY_EN
    localparam int unsigned PAR_W = AES_NBYTES;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned ENTRY_W = AES_STATE_W + ROUND_W + 1 + PAR_W;

    aes_state_t           keyed;
    logic                 in_last;
    logic                 accept;
    logic [ROUND_W-1:0]   exp_round;
    logic [ENTRY_W-1:0]   push_data;
    logic [ENTRY_W-1:0]   pop_data;

    assign keyed   = aes_xor_key(in_state, in_key);
    assign in_last = (in_round == ROUND_W'(NR));
    assign accept  = in_valid & in_ready;

`ifdef ADDKEY_PARITY_EN
    assign push_data = {keyed, in_round, in_last, aes_byte_parity(keyed)};
    assign {out_state, out_round, out_last, out_par} = pop_data;
`else
    assign push_data = {keyed, in_round, in_last};
    assign {out_state, out_round, out_last} = pop_data;
`endif

    // Next expected round follows the received index, which covers both in-sequence and resync cases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_round <= '0;
            round_err <= 1'b0;
        end else if (accept) begin
            if (in_round != exp_round) round_err <= 1'b1;
            exp_round <= in_last ? '0 : in_round + ROUND_W'(1);
        end
    end

    aes_skid_buf #(
        .WIDTH(ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (push_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pop_data)
    );

endmodule

// File: tb/tb_addroundkey_stage.sv
// Scoreboard bench for addroundkey_stage: driver pushes expected beats, monitor pops on each output transfer.
module tb_addroundkey_stage;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic [3:0]   in_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;
    logic         round_err;
`ifdef ADDKEY_PARITY_EN
    logic [15:0]  out_par;
`endif

    addroundkey_stage #(
        .NR(10),
        .ROUND_W(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_round  (in_round),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_round (out_round),
        .out_last  (out_last),
        .round_err (round_err)
`ifdef ADDKEY_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] state;
        logic [3:0]   round;
        logic         last;
        logic [15:0]  par;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    occ      = 0;
    int    m_exp    = 0;
    bit    m_err    = 1'b0;
    bit    last_push;
    bit    rand_ordy = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_push(input logic [127:0] st, input logic [127:0] key, input logic [3:0] r);
        beat_t e;
        e.state = st ^ key;
        e.round = r;
        e.last  = (int'(r) == NR);
        for (int b = 0; b < 16; b++) begin
            logic [7:0] byt;
            byt = e.state[8*b +: 8];
            e.par[b] = ^byt;
        end
        if (int'(r) != m_exp) m_err = 1'b1;
        m_exp = (int'(r) == NR) ? 0 : (int'(r) + 1) % 16;
        sb.push_back(e);
    endfunction

    task automatic tick();
        bit push;
        bit pop;
        @(negedge clk);
        chk("in_ready", 128'(in_ready), 128'(occ < 2));
        chk("out_valid", 128'(out_valid), 128'(occ != 0));
        chk("round_err", 128'(round_err), 128'(m_err));
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
        last_push = push;
        if (push) model_push(in_state, in_key, in_round);
        occ = occ + int'(push) - int'(pop);
        @(posedge clk);
        #1;
        if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [127:0] st, input logic [127:0] key, input logic [3:0] r, output int cyc);
        in_valid = 1'b1;
        in_state = st;
        in_key   = key;
        in_round = r;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!last_push && cyc < 100);
        if (!last_push) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: beat round %0d not accepted within %0d cycles", r, cyc);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        out_ready = 1'b1;
        guard = 0;
        while (occ != 0 && guard < 50) begin
            tick();
            guard++;
        end
        chk("drain_empty", 128'(occ != 0), 128'(0));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compare the head beat whenever a transfer is about to occur.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: out_state %h with empty scoreboard", out_state);
                end else begin
                    e = sb.pop_front();
                    chk("out_state", out_state, e.state);
                    chk("out_round", 128'(out_round), 128'(e.round));
                    chk("out_last", 128'(out_last), 128'(e.last));
`ifdef ADDKEY_PARITY_EN
                    chk("out_par", 128'(out_par), 128'(e.par));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [3:0] r;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        in_key    = '0;
        in_round  = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_state", out_state, 128'(0));
        chk("rst_out_round", 128'(out_round), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_round_err", 128'(round_err), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Known-answer beat, then rounds 1..10 back to back
        out_ready = 1'b1;
        send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 4'd0, cyc);
        #3;
        chk("kat_valid", 128'(out_valid), 128'(1));
        chk("kat_state", out_state, 128'h00102030405060708090a0b0c0d0e0f0);
        chk("kat_round", 128'(out_round), 128'(0));
        chk("kat_last", 128'(out_last), 128'(0));
        for (int i = 1; i <= NR; i++) begin
            send(rnd128(), rnd128(), 4'(i), cyc);
            chk("b2b_one_cycle", 128'(cyc), 128'(1));
        end
        drain();

        // Backpressure: two beats fill the buffer, third waits
        out_ready = 1'b0;
        send(rnd128(), rnd128(), 4'd0, cyc);
        send(rnd128(), rnd128(), 4'd1, cyc);
        chk("full_in_ready", 128'(in_ready), 128'(0));
        in_valid = 1'b1;
        in_state = rnd128();
        in_key   = rnd128();
        in_round = 4'd2;
        tick();
        tick();
        out_ready = 1'b1;
        send(in_state, in_key, 4'd2, cyc);
        chk("ready_after_pop", 128'(cyc), 128'(2));
        drain();

        // Complete the sequence, then 0,1,3 mismatch
        for (int i = 3; i <= NR; i++) send(rnd128(), rnd128(), 4'(i), cyc);
        send(rnd128(), rnd128(), 4'd0, cyc);
        send(rnd128(), rnd128(), 4'd1, cyc);
        chk("err_before", 128'(round_err), 128'(0));
        send(rnd128(), rnd128(), 4'd3, cyc);
        chk("err_set", 128'(round_err), 128'(1));
        send(rnd128(), rnd128(), 4'd4, cyc);
        send(rnd128(), rnd128(), 4'd5, cyc);
        chk("err_sticky", 128'(round_err), 128'(1));
        drain();

        // Random traffic with random backpressure and occasional bad rounds
        rand_ordy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            r = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_exp);
            send(rnd128(), rnd128(), r, cyc);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_ordy = 1'b0;
        drain();

`ifdef ADDKEY_PARITY_EN
        send(128'h0, 128'h01000000_00000000_00000000_00000003, 4'(m_exp), cyc);
        #3;
        chk("par_kat", 128'(out_par), 128'(16'h8000));
        drain();
`endif

        // Reset with two beats buffered
        out_ready = 1'b0;
        send(rnd128(), rnd128(), 4'(m_exp), cyc);
        send(rnd128(), rnd128(), 4'(m_exp), cyc);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_round_err", 128'(round_err), 128'(0));
        sb.delete();
        occ   = 0;
        m_exp = 0;
        m_err = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        send(rnd128(), rnd128(), 4'd0, cyc);
        drain();
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
